// File: rtl/neopixel_frame_buffer.sv
// Double-buffered pixel colour store feeding the NeoPixel serializer.
// Host writes the back bank; commits swap banks at a frame boundary, then the back bank is refreshed.
module neopixel_frame_buffer #(
  parameter int unsigned PIXELS_MAX  = 3,
  parameter int unsigned PIXELS_BITS = 2
) (
  input  logic                   CLK_10MHZ,
  input  logic                   RESET_N,
  input  logic                   WR_EN,
  input  logic [PIXELS_BITS-1:0] WR_PIXEL,
  input  logic [1:0]             WR_BYTE,
  input  logic [7:0]             WR_DATA,
  output logic                   WR_READY,
  input  logic                   COMMIT,
  output logic                   COMMIT_PENDING,
  input  logic                   FRAME_DONE,
  input  logic                   PIX_REQ,
  input  logic [PIXELS_BITS-1:0] PIX_INDEX,
  output logic [23:0]            PIX_VALUE,
  output logic                   PIX_VALID,
  output logic                   WR_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COPY
  } state_e;

  localparam logic [PIXELS_BITS:0]   PIX_LIMIT = (PIXELS_BITS + 1)'(PIXELS_MAX);
  localparam logic [PIXELS_BITS-1:0] CNT_LAST  = PIXELS_BITS'(PIXELS_MAX - 1);
  localparam logic [23:0]            MISCONF   = 24'h101010;

  state_e                 state_q;
  logic                   front_sel_q;
  logic [PIXELS_BITS-1:0] cnt_q;
  logic [23:0]            bank_q [2][PIXELS_MAX];
  logic [23:0]            pix_value_q;
  logic                   pix_valid_q;
  logic                   wr_err_q;
  logic                   commit_pending_q;

  logic back_sel;
  logic wr_ok;
  logic rd_ok;

  assign back_sel = ~front_sel_q;
  assign wr_ok    = ({1'b0, WR_PIXEL} < PIX_LIMIT) && (WR_BYTE != 2'd3);
  assign rd_ok    = ({1'b0, PIX_INDEX} < PIX_LIMIT);

  always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned p = 0; p < PIXELS_MAX; p++) begin
          bank_q[b][p] <= '0;
        end
      end
      state_q          <= IDLE;
      front_sel_q      <= 1'b0;
      cnt_q            <= '0;
      pix_value_q      <= '0;
      pix_valid_q      <= 1'b0;
      wr_err_q         <= 1'b0;
      commit_pending_q <= 1'b0;
    end else begin
      // Reads sample front_sel_q before any swap this edge, so the swap cycle returns the old front.
      pix_valid_q <= PIX_REQ;
      if (PIX_REQ) begin
        pix_value_q <= rd_ok ? bank_q[front_sel_q][PIX_INDEX] : MISCONF;
      end

      unique case (state_q)
        IDLE: begin
          if (WR_EN) begin
            if (wr_ok) begin
              case (WR_BYTE)
                2'd0:    bank_q[back_sel][WR_PIXEL][7:0]   <= WR_DATA;
                2'd1:    bank_q[back_sel][WR_PIXEL][15:8]  <= WR_DATA;
                2'd2:    bank_q[back_sel][WR_PIXEL][23:16] <= WR_DATA;
                default: ;
              endcase
            end else begin
              wr_err_q <= 1'b1;
            end
          end
          if (COMMIT) begin
            state_q          <= PENDING;
            commit_pending_q <= 1'b1;
            wr_err_q         <= 1'b0;
          end
        end

        PENDING: begin
          if (WR_EN) wr_err_q <= 1'b1;
          if (FRAME_DONE) begin
            front_sel_q      <= ~front_sel_q;
            commit_pending_q <= 1'b0;
            cnt_q            <= '0;
            state_q          <= COPY;
          end
        end

        COPY: begin
          if (WR_EN) wr_err_q <= 1'b1;
          // front_sel_q already points at the new front here.
          bank_q[back_sel][cnt_q] <= bank_q[front_sel_q][cnt_q];
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign WR_READY       = (state_q == IDLE);
  assign COMMIT_PENDING = commit_pending_q;
  assign PIX_VALUE      = pix_value_q;
  assign PIX_VALID      = pix_valid_q;
  assign WR_ERR         = wr_err_q;

endmodule

// File: doc/neopixel_frame_buffer.md
Name: neopixel_frame_buffer

Overview:
- Upstream stage of the NeoPixel serializer. Holds the colour of every pixel in a strip, replacing the serializer's hard-coded colour case.
- A host writes bytes into a back bank. The serializer reads 24-bit pixel values from a front bank.
- A commit request swaps the banks only at a frame boundary, so a strip never shows a half-updated frame.
- After each swap, an internal copy refreshes the back bank so the host can do partial updates.

Parameters:
- PIXELS_MAX, 3: number of LEDs in the strip (entries per bank).
- PIXELS_BITS, 2: index width; must satisfy 2^PIXELS_BITS >= PIXELS_MAX.

Ports:
- CLK_10MHZ  in  1  system clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- WR_EN  in  1  host byte write strobe.
- WR_PIXEL  in  PIXELS_BITS  target pixel index.
- WR_BYTE  in  2  byte lane: 0 = bits[7:0] green, 1 = bits[15:8] red, 2 = bits[23:16] blue; 3 is invalid.
- WR_DATA  in  8  byte value.
- WR_READY  out  1  high when writes are accepted.
- COMMIT  in  1  single-cycle pulse requesting a bank swap.
- COMMIT_PENDING  out  1  a commit is waiting for a frame boundary.
- FRAME_DONE  in  1  serializer pulse on entering its reset (latch) phase.
- PIX_REQ  in  1  serializer read request.
- PIX_INDEX  in  PIXELS_BITS  pixel to read.
- PIX_VALUE  out  24  pixel colour, in the serializer's bit order: blue in [23:16], red in [15:8], green in [7:0].
- PIX_VALID  out  1  PIX_VALUE is valid this cycle.
- WR_ERR  out  1  sticky error flag.

Behaviour:
- Storage:
  - Two banks, bank0 and bank1, each PIXELS_MAX x 24-bit registers.
  - Register front_sel selects the front bank; the back bank is the other one.
- Reset (async, RESET_N = 0), all at once:
  - all bank entries = 24'h000000; front_sel = 0; state = IDLE; copy counter = 0.
  - PIX_VALUE = 0, PIX_VALID = 0, WR_ERR = 0, COMMIT_PENDING = 0.
  - WR_READY = 1 once reset releases.
  - Reset mid-COPY or mid-PENDING aborts the operation with no partial state kept.
- States: IDLE, PENDING, COPY. WR_READY = (state == IDLE), combinational.
- IDLE:
  - WR_EN with WR_PIXEL < PIXELS_MAX and WR_BYTE != 3 updates that byte of back[WR_PIXEL] at the clock edge; the other bytes are unchanged.
  - An invalid pixel index or lane 3: write dropped, WR_ERR set.
  - COMMIT goes to PENDING. If COMMIT and WR_EN occur in the same cycle, the write lands first.
- PENDING:
  - COMMIT_PENDING = 1.
  - WR_EN is dropped and sets WR_ERR.
  - A further COMMIT is ignored.
  - On FRAME_DONE: toggle front_sel, clear COMMIT_PENDING, go to COPY.
- IDLE with COMMIT and FRAME_DONE in the same cycle: goes only to PENDING; the swap waits for the next FRAME_DONE.
- COPY:
  - One entry per cycle, copy counter i = 0..PIXELS_MAX-1: back[i] <= front[i] (new front).
  - Lasts exactly PIXELS_MAX cycles, then IDLE with the counter cleared to 0.
  - WR_EN is dropped and sets WR_ERR.
  - COMMIT during COPY is ignored.
  - FRAME_DONE is ignored outside PENDING.
- Read path, 1-cycle latency:
  - PIX_REQ sampled at edge N gives PIX_VALID = 1 and PIX_VALUE = front[PIX_INDEX] in cycle N+1.
  - PIX_INDEX >= PIXELS_MAX returns 24'h101010 (the "misconfigured" colour) with PIX_VALID = 1.
  - Back-to-back requests give continuous PIX_VALID.
  - Without PIX_REQ, PIX_VALID = 0 and PIX_VALUE holds its last value.
  - Reads in any state always use the current front bank. A read in the swap cycle returns the pre-swap front.
- WR_ERR stays set until reset or until a COMMIT is accepted from IDLE, which clears it.

Test Plan:
1. Reset, then PIX_REQ with index 0,1,2 back-to-back -> PIX_VALID high for 3 cycles starting 1 cycle later, values 24'h000000; index 3 -> 24'h101010.
2. Write pixel 1, lanes 0/1/2 = 8'h00/8'h88/8'h00, read pixel 1 -> 24'h000000 (still back bank); COMMIT, FRAME_DONE 5 cycles later -> COMMIT_PENDING high during the wait, read -> 24'h008800.
3. After the swap in test 2, check WR_READY low for exactly 3 cycles; then write only lane 2 of pixel 1 = 8'h90, commit + FRAME_DONE -> read 24'h908800 (copy preserved the other lanes).
4. WR_EN during PENDING, WR_EN during COPY, and writes to pixel 3 or lane 3 -> banks unchanged, WR_ERR = 1; next accepted COMMIT clears WR_ERR.
5. COMMIT and FRAME_DONE in the same cycle -> no swap, COMMIT_PENDING = 1; next FRAME_DONE -> swap; FRAME_DONE in IDLE -> front_sel unchanged.
6. Assert RESET_N low on the 2nd COPY cycle -> outputs immediately at reset values; after release WR_READY = 1 and all reads return 24'h000000.
